// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared widths, flag bit positions, ALU op codes and result entry
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_XOR = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic [3:0]        flags;
  } result_entry_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_fifo2 : 2-entry strict FIFO with 1-bit pointers and occupancy count
// Revision: 1.0
// ---------------------------------------------------------------------------
module result_fifo2
  import alu_pkg::*;
#(
  parameter int ENTRY_W = $bits(result_entry_t)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] head_data,
  output logic [1:0]         occupancy
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic [1:0]         occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) begin
      // Flush wins over any same-cycle push or pop.
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data = (occ_q == 2'd0) ? '0 : mem_q[head_q];
  assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_result_stage : ALU result buffer toward writeback plus NZCV flag register
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int RD_W   = alu_pkg::RD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_overflow,
  input  logic              in_negative,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic [3:0]        out_flags,
  output logic [3:0]        flags_q,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = DATA_W + RD_W + 4;

  logic               w_accept;
  logic               w_pop;
  logic [3:0]         w_in_flags;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head_data;
  logic [3:0]         flags_d;

  // Ready and valid come from registered occupancy only.
  assign in_ready  = (occupancy != 2'd2);
  assign out_valid = (occupancy != 2'd0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_in_flags  = pack_flags(in_negative, in_zero, in_carry, in_overflow);
  assign w_push_data = {in_result, in_rd, w_in_flags};

  result_fifo2 #(
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_accept),
    .pop       (w_pop),
    .push_data (w_push_data),
    .head_data (w_head_data),
    .occupancy (occupancy)
  );

  assign out_result = w_head_data[ENTRY_W-1 -: DATA_W];
  assign out_rd     = w_head_data[4 +: RD_W];
  assign out_flags  = w_head_data[3:0];

  always_comb begin
    flags_d = flags_q;
    if (w_accept && in_set_flags && !flush) begin
      flags_d = w_in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_result_stage : directed self-checking bench for alu_result_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry, in_zero, in_overflow, in_negative;
  logic [4:0]  in_rd;
  logic        in_set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [3:0]  out_flags;
  logic [3:0]  flags_q;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_negative  (in_negative),
    .in_rd        (in_rd),
    .in_set_flags (in_set_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_flags    (out_flags),
    .flags_q      (flags_q),
    .occupancy    (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic n, input logic z, input logic c, input logic ov,
                       input logic sf);
    in_valid     = v;
    in_result    = res;
    in_rd        = rd;
    in_negative  = n;
    in_zero      = z;
    in_carry     = c;
    in_overflow  = ov;
    in_set_flags = sf;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset values
    chk("rst_in_ready",   in_ready,   1'b1);
    chk("rst_out_valid",  out_valid,  1'b0);
    chk("rst_occupancy",  occupancy,  2'd0);
    chk("rst_flags_q",    flags_q,    4'b0000);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_rd",     out_rd,     5'd0);
    chk("rst_out_flags",  out_flags,  4'b0000);
    rst_n = 1'b1;
    step();

    // Single pass
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("single_out_valid",  out_valid,  1'b1);
    chk("single_out_result", out_result, 32'h5);
    chk("single_out_rd",     out_rd,     5'd3);
    chk("single_flags_q",    flags_q,    4'b0000);
    chk("single_occupancy",  occupancy,  2'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("single_drained", occupancy, 2'd0);

    // Flag update: 0xFFFFFFFF + 1 -> 0, Z=1 C=1
    drive(1'b1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("flag_set_flags_q",   flags_q,   4'b0110);
    chk("flag_set_out_flags", out_flags, 4'b0110);
    // XOR without set_flags leaves flags_q alone
    drive(1'b1, 32'h0000_00F0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("flag_hold_flags_q", flags_q,    4'b0110);
    chk("flag_hold_result",  out_result, 32'hF0);
    chk("flag_hold_rd",      out_rd,     5'd2);
    chk("flag_hold_oflags",  out_flags,  4'b1000);
    chk("flag_hold_occ",     occupancy,  2'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_occ1",   occupancy, 2'd1);
    chk("bp_ready1", in_ready,  1'b1);
    in_result = 32'hB;
    step();
    chk("bp_occ2",   occupancy, 2'd2);
    chk("bp_ready2", in_ready,  1'b0);
    in_result = 32'hC;
    step();
    chk("bp_occ_full",   occupancy,  2'd2);
    chk("bp_head_held",  out_result, 32'hA);
    chk("bp_ready_low",  in_ready,   1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_pop_a_occ",  occupancy,  2'd1);
    chk("bp_head_b",     out_result, 32'hB);
    step();
    chk("bp_head_c",     out_result, 32'hC);
    chk("bp_occ_c",      occupancy,  2'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drained",    occupancy,  2'd0);

    // Simultaneous push/pop at occupancy 1
    drive(1'b1, 32'd100, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 10; i++) begin
      in_result = 32'd100 + i;
      step();
      chk("stream_occ",    occupancy,  2'd1);
      chk("stream_result", out_result, 32'd100 + i);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", occupancy, 2'd0);

    // Flush with an accept pending
    out_ready = 1'b0;
    drive(1'b1, 32'h7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("pre_flush_flags", flags_q,   4'b1000);
    chk("pre_flush_occ",   occupancy, 2'd1);
    drive(1'b1, 32'h8, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ",       occupancy,  2'd0);
    chk("flush_out_valid", out_valid,  1'b0);
    chk("flush_flags_q",   flags_q,    4'b1000);
    chk("flush_out_res",   out_result, 32'h0);
    step();
    chk("flush_stays_empty", occupancy, 2'd0);

    // Asynchronous reset mid-stream at occupancy 2
    drive(1'b1, 32'h11, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    in_result = 32'h22;
    step();
    in_valid = 1'b0;
    chk("areset_pre_occ",   occupancy, 2'd2);
    chk("areset_pre_flags", flags_q,   4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_occ",       occupancy, 2'd0);
    chk("areset_out_valid", out_valid, 1'b0);
    chk("areset_flags_q",   flags_q,   4'b0000);
    chk("areset_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
